// File: rtl/seg7_scan.sv
`default_nettype none
// ============================================================================
// Module   : seg7_scan
// Purpose  : Eight-digit multiplexed seven-segment driver. Shows one 32-bit
//            word (RegDisplay or Adr) as hex, one digit lit at a time. The
//            word is snapshotted only at frame boundaries so a frame never
//            mixes two values, and the decimal point on digit 0 flags frames
//            whose word differs from the previous frame.
// Ports    : clk        - system clock
//            reset      - synchronous, active-high reset
//            RegDisplay - register-file debug word (sel = 0)
//            Adr        - memory address (sel = 1)
//            sel        - source select, sampled at frame boundary only
//            an[7:0]    - digit enables, active-low (digit 0 rightmost)
//            seg[6:0]   - segments {g,f,e,d,c,b,a}, active-low
//            dp         - decimal point, active-low
// Params   : REFRESH_DIV - cycles each digit stays lit (1 .. 2^20)
//            BLANK_LZ    - 1 blanks leading-zero digits
// Revision : 1.0 - initial release
// ============================================================================
module seg7_scan #(
  parameter int REFRESH_DIV = 50000,
  parameter bit BLANK_LZ    = 1'b0
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] RegDisplay,
  input  logic [31:0] Adr,
  input  logic        sel,
  output logic [7:0]  an,
  output logic [6:0]  seg,
  output logic        dp
);

  localparam logic [19:0] DIV_LAST = 20'(REFRESH_DIV - 1);

  logic [19:0] div_cnt;
  logic [2:0]  digit;
  logic [31:0] snap;
  logic        changed;

  logic        tick;
  logic [31:0] new_word;
  logic [3:0]  nibble;
  logic [7:0]  lit;
  logic        blank;

  assign tick     = (div_cnt == DIV_LAST);
  assign new_word = sel ? Adr : RegDisplay;

  // Reset has priority over tick, so a boundary coinciding with reset
  // captures nothing.
  always_ff @(posedge clk) begin
    if (reset) begin
      div_cnt <= '0;
      digit   <= '0;
      snap    <= '0;
      changed <= 1'b0;
    end else if (tick) begin
      div_cnt <= '0;
      digit   <= digit + 3'd1;
      if (digit == 3'd7) begin
        snap    <= new_word;
        changed <= (new_word != snap);
      end
    end else begin
      div_cnt <= div_cnt + 20'd1;
    end
  end

  // lit[i]: some nibble at position i or above is non-zero. Digit 0 is
  // always lit so an all-zero word still shows a single "0".
  assign lit[0] = 1'b1;
  for (genvar i = 1; i < 8; i++) begin : g_lz
    assign lit[i] = |snap[31:4*i];
  end

  assign nibble = snap[{digit, 2'b00} +: 4];
  assign blank  = BLANK_LZ && !lit[digit];

  function automatic logic [6:0] hex_seg(input logic [3:0] n);
    case (n)
      4'h0: hex_seg = 7'h40;
      4'h1: hex_seg = 7'h79;
      4'h2: hex_seg = 7'h24;
      4'h3: hex_seg = 7'h30;
      4'h4: hex_seg = 7'h19;
      4'h5: hex_seg = 7'h12;
      4'h6: hex_seg = 7'h02;
      4'h7: hex_seg = 7'h78;
      4'h8: hex_seg = 7'h00;
      4'h9: hex_seg = 7'h10;
      4'hA: hex_seg = 7'h08;
      4'hB: hex_seg = 7'h03;
      4'hC: hex_seg = 7'h46;
      4'hD: hex_seg = 7'h21;
      4'hE: hex_seg = 7'h06;
      default: hex_seg = 7'h0E;
    endcase
  endfunction

  // Outputs depend on registers only; no input-to-output path.
  always_comb begin
    an  = 8'hFF;
    seg = 7'h7F;
    dp  = 1'b1;
    if (!blank) begin
      an  = ~(8'b0000_0001 << digit);
      seg = hex_seg(nibble);
    end
    if (digit == 3'd0 && changed) begin
      dp = 1'b0;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_seg7_scan.sv
`default_nettype none
// ============================================================================
// Module   : tb_seg7_scan
// Purpose  : Self-checking bench for seg7_scan with REFRESH_DIV = 4. Two
//            instances share stimulus: one without and one with leading-zero
//            blanking. A reference model tracks cycles since reset and the
//            displayed word, and derives the expected display from them.
// Revision : 1.0 - initial release
// ============================================================================
module tb_seg7_scan;

  localparam int DIV   = 4;
  localparam int FRAME = 8 * DIV;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] RegDisplay;
  logic [31:0] Adr;
  logic        sel;
  logic [7:0]  an0, an1;
  logic [6:0]  seg0, seg1;
  logic        dp0, dp1;

  int checks = 0;
  int errors = 0;

  seg7_scan #(.REFRESH_DIV(DIV), .BLANK_LZ(1'b0)) dut0 (
    .clk(clk), .reset(reset), .RegDisplay(RegDisplay), .Adr(Adr), .sel(sel),
    .an(an0), .seg(seg0), .dp(dp0)
  );

  seg7_scan #(.REFRESH_DIV(DIV), .BLANK_LZ(1'b1)) dut1 (
    .clk(clk), .reset(reset), .RegDisplay(RegDisplay), .Adr(Adr), .sel(sel),
    .an(an1), .seg(seg1), .dp(dp1)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Reference model: t counts clock edges since reset; a frame boundary is
  // the edge where t mod FRAME is FRAME-1.
  logic [6:0]  hex_tab [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12,
                                7'h02, 7'h78, 7'h00, 7'h10, 7'h08, 7'h03,
                                7'h46, 7'h21, 7'h06, 7'h0E};
  int          t        = 0;
  logic [31:0] m_snap   = '0;
  logic        m_changed = 1'b0;

  task automatic model_edge();
    logic [31:0] w;
    if (reset) begin
      t = 0; m_snap = '0; m_changed = 1'b0;
    end else begin
      if (t % FRAME == FRAME - 1) begin
        w = sel ? Adr : RegDisplay;
        m_changed = (w != m_snap);
        m_snap    = w;
      end
      t++;
    end
  endtask

  task automatic chk8(string tag, logic [7:0] obs, logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s t=%0d observed=%h expected=%h", tag, t, obs, exp);
    end
  endtask

  task automatic check_outputs();
    int d;
    logic [3:0] nib;
    logic lit;
    logic [7:0] exp_an;
    logic exp_dp;
    d       = (t / DIV) % 8;
    nib     = m_snap[4*d +: 4];
    lit     = (d == 0) || ((m_snap >> (4*d)) != 0);
    exp_an  = ~(8'(1) << d);
    exp_dp  = !(d == 0 && m_changed);
    chk8("an",       an0,  exp_an);
    chk8("seg",      {1'b0, seg0}, {1'b0, hex_tab[nib]});
    chk8("dp",       {7'b0, dp0},  {7'b0, exp_dp});
    chk8("an_lz",    an1,  lit ? exp_an : 8'hFF);
    chk8("seg_lz",   {1'b0, seg1}, lit ? {1'b0, hex_tab[nib]} : 8'h7F);
    chk8("dp_lz",    {7'b0, dp1},  {7'b0, exp_dp});
    chk8("div_cnt",  8'(dut0.div_cnt), 8'(t % DIV));
  endtask

  // One clock: inputs already driven, advance model at the edge, check #1 later.
  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
    check_outputs();
  endtask

  task automatic run(int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic run_to_phase(int ph);
    for (int i = 0; i < FRAME && (t % FRAME) != ph; i++) step();
  endtask

  initial begin
    reset = 1'b1; RegDisplay = 32'h1234_5678; Adr = '0; sel = 1'b0;
    #1;
    // Reset
    run(2);
    chk8("reset_an",  an0, 8'hFE);
    chk8("reset_seg", {1'b0, seg0}, 8'h40);
    chk8("reset_dp",  {7'b0, dp0}, 8'h01);
    chk8("reset_an_lz", an1, 8'hFE);
    reset = 1'b0;
    run(FRAME - 1);                       // first frame still zero
    chk8("first_frame_zero", 8'(dut0.snap), 8'h00);
    run(FRAME + 8);                       // 12345678 displayed, cadence checked
    chk8("snap_12345678", 8'(dut0.snap), 8'h78);

    // Tear-free snapshot
    RegDisplay = 32'h0000_FFFF;
    run_to_phase(0);
    run_to_phase(3 * DIV + 1);            // digit 3 of a frame showing 0000FFFF
    RegDisplay = 32'hABCD_0000;
    run(2 * FRAME);

    // Source select mid-frame
    Adr = 32'h0000_0010;
    run_to_phase(2 * DIV);
    sel = 1'b1;
    run(2 * FRAME);
    chk8("adr_selected", 8'(dut0.snap), 8'h10);

    // Blanking patterns
    sel = 1'b0; RegDisplay = 32'h0000_00A0;
    run(2 * FRAME);
    RegDisplay = 32'h0;
    run(2 * FRAME);

    // Reset coincident with boundary tick
    RegDisplay = 32'hDEAD_BEEF;
    run_to_phase(FRAME - 1);
    reset = 1'b1;
    step();
    chk8("rst_tick_snap",    8'(dut0.snap), 8'h00);
    chk8("rst_tick_changed", {7'b0, dut0.changed}, 8'h00);
    chk8("rst_tick_an",      an0, 8'hFE);
    reset = 1'b0;
    run(FRAME);

    // Randomized traffic, including occasional mid-frame resets
    for (int i = 0; i < 1500; i++) begin
      if ($urandom_range(0, 7) == 0) RegDisplay = $urandom();
      if ($urandom_range(0, 3) == 0)
        RegDisplay = RegDisplay >> (4 * $urandom_range(0, 7));
      if ($urandom_range(0, 7) == 0) Adr = $urandom() >> $urandom_range(0, 31);
      if ($urandom_range(0, 15) == 0) sel = ~sel;
      reset = ($urandom_range(0, 299) == 0);
      step();
    end
    reset = 1'b0;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/seg7_scan.md
# seg7_scan

Eight-digit multiplexed seven-segment driver that consumes the processor's debug outputs (`RegDisplay`, `Adr`) and shows one 32-bit word as hexadecimal on the board display. It sits directly downstream of the `arm` core in the FPGA top level. A refresh divider scans one digit at a time. The displayed word is snapshotted only at frame boundaries, so no frame mixes two values. A change indicator flags frames whose word differs from the previous frame.

## Interface

Parameters:
- `REFRESH_DIV`, default 50000: clock cycles each digit stays lit. Legal range is at least 1, with a maximum of 2^20.
- `BLANK_LZ`, default 0: 1 blanks leading-zero digits.

Ports:
- `clk`  in  1  system clock; single clock domain.
- `reset`  in  1  synchronous, active-high reset.
- `RegDisplay`  in  32  register-file debug word from the core.
- `Adr`  in  32  memory address from the core.
- `sel`  in  1  source select: 0 selects `RegDisplay`, 1 selects `Adr`.
- `an`  out  8  digit enables, active-low; exactly one bit is low unless that digit is blanked.
- `seg`  out  7  segments `{g,f,e,d,c,b,a}`, active-low.
- `dp`  out  1  decimal point, active-low.

## Operation

**Registers**
- `div_cnt`: 20-bit divider counter.
- `digit`: 3-bit digit index.
- `snap`: 32-bit displayed word.
- `changed`: 1-bit change flag.

**Divider and tick**
- `tick` = (`div_cnt` == `REFRESH_DIV`-1).
- On `tick`, `div_cnt` wraps to 0; otherwise it increments.
- With `REFRESH_DIV`=1, `tick` is asserted every cycle.

**Digit scan**
- On `tick`, `digit` increments modulo 8 (7 wraps to 0).
- A frame is 8 consecutive `tick`s.

**Frame boundary** (`tick` while `digit`==7):
- `snap` <= `sel` ? `Adr` : `RegDisplay`. `sel` is sampled only here.
- `changed` <= (new value != current `snap`).
- Inputs are ignored at all other times.

**Output decode** (combinational from registers only; no input-to-output path)
- Digit i shows nibble `snap[4i+3:4i]` and drives `an[i]`=0, all other `an` bits 1. Digit 0 is the rightmost.
- Hex patterns for `seg`, nibbles 0–F: 40, 79, 24, 30, 19, 12, 02, 78, 00, 10, 08, 03, 46, 21, 06, 0E (hex).
- `dp` = 0 only when `digit`==0 and `changed`==1; otherwise 1.

**Leading-zero blanking** (`BLANK_LZ`=1)
- Digit i>0 is blanked when all nibbles i..7 of `snap` are zero.
- Blanked means `an` is all ones and `seg`=7F.
- Digit 0 is never blanked, so a zero word shows a single "0".

**Reset**
- `div_cnt`=0, `digit`=0, `snap`=0, `changed`=0.
- Outputs therefore read `an`=FE, `seg`=40, `dp`=1, with or without `BLANK_LZ`.

## Timing

- Update latency: an input value present at the frame-boundary `tick` edge appears on digit 0 immediately after that edge. Worst case, a change waits one full frame, 8·`REFRESH_DIV` cycles, before it is captured.
- Each digit is lit for exactly `REFRESH_DIV` cycles; `an` changes only on `tick` edges (or on reset).
- `changed` holds for the whole frame and is re-evaluated at every frame boundary.
- `sel` changing mid-frame has no effect until the next boundary.
- `reset` asserted mid-frame wins over `tick` in the same cycle and returns all state to reset values on the next edge.
- Inputs changing in the same cycle as the boundary `tick` are captured with the value present at that edge.

## Test plan

All scenarios use `REFRESH_DIV`=4.

1. **Reset.** Assert `reset` for 2 cycles with `RegDisplay`=12345678.
   - Required: `an`=FE, `seg`=40, `dp`=1.
   - After release, the first frame still shows 00000000.
   - From cycle 32 after release, digits 0..7 show 8,7,6,5,4,3,2,1 (`seg` 00,78,02,12,19,30,24,79).
2. **Scan cadence.**
   - Required: `an` sequence FE, FD, FB, F7, EF, DF, BF, 7F, FE, each held exactly 4 cycles.
   - Required: `div_cnt` wraps 3→0 on each step.
3. **Tear-free snapshot.** Change `RegDisplay` from 0000FFFF to ABCD0000 while `digit`==3.
   - Required: the rest of the frame still shows F on digits 0–3 and 0 on digits 4–7.
   - Required: the next frame shows 0 on digits 0–3 and D,C,b,A on digits 4–7, with `dp`=0 on digit 0 for that frame only.
4. **Source select.** Set `Adr`=00000010 and toggle `sel` 0→1 mid-frame.
   - Required: the switch takes effect at the next boundary only.
   - Required: digit 1 then shows `seg`=79 and digit 0 shows `seg`=40.
5. **Blanking.** With `BLANK_LZ`=1 and `RegDisplay`=000000A0:
   - Required: digits 0 and 1 are lit (`seg` 40, then 08).
   - Required: during digits 2–7, `an`=FF and `seg`=7F.
   - With `RegDisplay`=0, only digit 0 lights, showing `seg`=40.
6. **Reset during scan.** Assert `reset` coincident with a boundary `tick`.
   - Required: no capture occurs; the next state is `an`=FE, `snap`=0, `changed`=0.
